// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: fetch FSM states, the NOP
// presented while the queue is empty, and the queued {pc, insn} entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two queue of fetched {pc, insn} pairs with synchronous flush.
// Head entry is read straight from storage so a push is visible the next cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_insn,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_insn
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= '{pc: push_pc, insn: push_insn};
        end
    end

    assign head_pc   = mem[rd_ptr].pc;
    assign head_insn = mem[rd_ptr].insn;

endmodule

// File: rtl/insn_fetch_buffer.sv
// RV32I fetch stage: PC, single-outstanding imem fetch FSM and instruction queue.
// Optional FETCH_MISALIGN_CHECK_EN adds the fetch_misalign flag for unaligned redirects.
module insn_fetch_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn_out,
    output logic [31:0] pc_out
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   redirect_target;
    logic [CW-1:0] count;
    logic [31:0]   head_pc;
    logic [31:0]   head_insn;
    logic          granted;
    logic          push;
    logic          pop;
    logic          has_space;
    logic          space_after_push;

    assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
    assign granted          = (state == REQ) && imem_gnt;
    assign pop              = insn_valid && insn_ready && !redirect;
    assign push             = (state == WAIT) && imem_rvalid && !redirect;
    assign has_space        = count < DEPTH_C;
    assign space_after_push = pop || (count < DEPTH_M1);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_pc   (req_pc),
        .push_insn (imem_rdata),
        .pop       (pop),
        .count     (count),
        .head_pc   (head_pc),
        .head_insn (head_insn)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_next;
            if (granted) req_pc <= fetch_pc;
            if (redirect) begin
                fetch_pc <= redirect_target;
            end else if (granted) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // A response arriving together with a redirect completes the fetch, so the
    // FSM skips DROP in that case instead of waiting for a response that never comes.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (redirect || has_space) state_next = REQ;
            end
            REQ: begin
                if (imem_gnt)      state_next = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = (redirect || space_after_push) ? REQ : IDLE;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid)   state_next = has_space ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req   = (state == REQ);
    assign imem_addr  = fetch_pc;
    assign insn_valid = (count != '0);
    assign insn_out   = insn_valid ? head_insn : NOP_INSN;
    assign pc_out     = insn_valid ? head_pc : RESET_PC;

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end
`endif

endmodule
